cp0_unit: RTL

- Coprocessor-0 responder for the 5-stage MIPS pipeline. The datapath is the initiator; this block answers its CP0 interface.
- Serves MFC0 reads and MTC0 writes issued from the ID stage.
- Owns the free-running Count/Compare timer and external interrupt capture.
- Issues the interrupt or ERET redirect (jump_en/jump_addr), which the datapath uses to load PC and flush ID.

---
 rtl/cp0_unit.sv | 70 +++++++
 1 files changed

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor-0 responder (MFC0/MTC0, Count/Compare timer, interrupt/ERET redirect)
module cp0_unit #(
  parameter logic [31:0] EXC_BASE = 32'h0000_0008,
  parameter bit          TIMER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  oper,
  input  logic [4:0]  addr_r,
  output logic [31:0] data_r,
  input  logic [4:0]  addr_w,
  input  logic [31:0] data_w,
  input  logic [31:0] ret_addr,
  input  logic        ir_in,
  output logic        jump_en,
  output logic [31:0] jump_addr
);
  logic [31:0] ehbr, count, compare, epc, sr_val, cause_val;
  logic [7:0]  im;
  logic        exl, ie, ip7, ip2, s1, s2, s3;
  logic        wr, int_take, eret_take;
  always_comb begin
    wr        = en && oper == 2'd2;
    eret_take = en && oper == 2'd3;
    sr_val    = {16'b0, im, 6'b0, exl, ie};
    cause_val = {16'b0, ip7, 4'b0, ip2, 10'b0};
    int_take  = en & ie & ~exl & (|(cause_val[15:8] & im)) & (oper != 2'd3);
    jump_en   = ~rst & (int_take | eret_take);
    jump_addr = eret_take ? epc : ehbr;
    data_r    = addr_r == 5'd7  ? ehbr :
                addr_r == 5'd9  ? count :
                addr_r == 5'd11 ? compare :
                addr_r == 5'd12 ? sr_val :
                addr_r == 5'd13 ? cause_val :
                addr_r == 5'd14 ? epc : 32'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ehbr    <= EXC_BASE;
      count   <= '0;
      compare <= '0;
      epc     <= '0;
      im      <= '0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      ip7     <= 1'b0;
      ip2     <= 1'b0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
    end else begin
      s1 <= ir_in;
      s2 <= s1;
      s3 <= s2;
      if (wr && addr_w == 5'd7) ehbr <= data_w;
      if (wr && addr_w == 5'd11) compare <= data_w;
      count <= (wr && addr_w == 5'd9) ? data_w : count + 32'(TIMER_EN);
      // Compare write acknowledges the timer and beats a same-edge match
      ip7 <= (wr && addr_w == 5'd11) ? 1'b0 : ip7 | (TIMER_EN && count == compare && compare != 32'b0);
      ip2 <= (s2 & ~s3) | (ip2 & ~(int_take & im[2]));
      if (wr && addr_w == 5'd12) begin
        im <= data_w[15:8];
        ie <= data_w[0];
      end
      exl <= int_take ? 1'b1 : eret_take ? 1'b0 : (wr && addr_w == 5'd12) ? data_w[1] : exl;
      epc <= int_take ? ret_addr : (wr && addr_w == 5'd14) ? data_w : epc;
    end
  end
endmodule
